// File: rtl/snake_body_engine.sv
// Snake body store and incremental redraw sequencer for the 160x120 VGA game.
// Each step erases the old tail square, shifts the body, then draws the new head.
module snake_body_engine #(
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120,
   parameter int SEG = 10,
   parameter int MAX_LEN = 8,
   parameter int INIT_LEN = 2,
   parameter int X0 = 40,
   parameter int Y0 = 60,
   parameter logic [2:0] FG = 3'b010,
   parameter logic [2:0] BG = 3'b000,
   parameter int LW = $clog2(MAX_LEN + 1)
) (
   input  logic          Clock,
   input  logic          Reset,
   input  logic          step,
   input  logic [1:0]    dir,
   input  logic          dir_valid,
   input  logic          grow,
   output logic [7:0]    pix_x,
   output logic [6:0]    pix_y,
   output logic [2:0]    pix_colour,
   output logic          plot,
   output logic          busy,
   output logic          dead,
   output logic [LW-1:0] length,
   output logic [7:0]    head_x,
   output logic [6:0]    head_y,
   output logic          step_drop
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int CW = (SEG > 1) ? $clog2(SEG) : 1;
   localparam logic [CW-1:0] CMAX = CW'(SEG - 1);
   localparam logic signed [8:0] DS = 9'(SEG);
   localparam logic signed [8:0] XMAX = 9'(XSCREEN - SEG);
   localparam logic signed [8:0] YMAX = 9'(YSCREEN - SEG);

   typedef enum logic [2:0] {
      INIT_DRAW, IDLE, CALC, CHECK, ERASE, SHIFT, DRAW
   } state_t;

   state_t        state;
   logic [7:0]    seg_x [MAX_LEN];
   logic [6:0]    seg_y [MAX_LEN];
   logic [1:0]    cur_dir;
   logic [1:0]    pend_dir;
   logic          grow_pend;
   logic          g;
   logic [7:0]    nh_x;
   logic [6:0]    nh_y;
   logic [IW-1:0] idx;
   logic [CW-1:0] xc;
   logic [CW-1:0] yc;

   logic signed [8:0] nx;
   logic signed [8:0] ny;
   logic          off;
   logic [LW-1:0] last_idx;
   logic          idx_last;
   logic          hit;
   logic          rev;
   logic          last_px;
   logic [CW-1:0] xc_n;
   logic [CW-1:0] yc_n;
   logic [IW-1:0] sel;
   logic [7:0]    sel_x;
   logic [6:0]    sel_y;
   logic [2:0]    pcol;

   assign busy = (state != IDLE);
   assign head_x = seg_x[0];
   assign head_y = seg_y[0];

   assign last_idx = LW'(length - LW'(1));
   assign idx_last = (LW'(idx) == last_idx);
   assign hit = (nh_x == seg_x[idx]) && (nh_y == seg_y[idx]);
   assign rev = ((dir ^ cur_dir) == 2'b11) && (length > LW'(1));
   assign last_px = (xc == CMAX) && (yc == CMAX);

   // Candidate head is signed so a move past the left or top edge goes negative.
   always_comb begin
      nx = $signed({1'b0, seg_x[0]});
      ny = $signed({2'b00, seg_y[0]});
      unique case (pend_dir)
         2'b00: nx = nx + DS;
         2'b01: ny = ny + DS;
         2'b10: ny = ny - DS;
         2'b11: nx = nx - DS;
         default: nx = nx;
      endcase
      off = (nx < 0) || (nx > XMAX) || (ny < 0) || (ny > YMAX);
   end

   always_comb begin
      if (xc == CMAX) begin
         xc_n = '0;
         yc_n = last_px ? '0 : yc + CW'(1);
      end else begin
         xc_n = xc + CW'(1);
         yc_n = yc;
      end
   end

   always_comb begin
      sel = '0;
      pcol = FG;
      if (state == INIT_DRAW) begin
         sel = idx;
      end else if (state == ERASE) begin
         sel = IW'(last_idx);
         pcol = BG;
      end
      sel_x = seg_x[sel];
      sel_y = seg_y[sel];
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            seg_x[i] <= 8'(X0 - i * SEG);
            seg_y[i] <= 7'(Y0);
         end
         state      <= INIT_DRAW;
         length     <= LW'(INIT_LEN);
         cur_dir    <= 2'b00;
         pend_dir   <= 2'b00;
         grow_pend  <= 1'b0;
         g          <= 1'b0;
         nh_x       <= '0;
         nh_y       <= '0;
         idx        <= '0;
         xc         <= '0;
         yc         <= '0;
         dead       <= 1'b0;
         plot       <= 1'b0;
         step_drop  <= 1'b0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_colour <= '0;
      end else begin
         plot      <= 1'b0;
         step_drop <= step && ((state != IDLE) || dead);
         if (dir_valid && !rev)
            pend_dir <= dir;
         if (state == CALC)
            grow_pend <= grow;
         else if (grow)
            grow_pend <= 1'b1;

         if (state == INIT_DRAW || state == ERASE || state == DRAW) begin
            plot       <= 1'b1;
            pix_x      <= 8'(sel_x + 8'(xc));
            pix_y      <= 7'(sel_y + 7'(yc));
            pix_colour <= pcol;
            xc         <= xc_n;
            yc         <= yc_n;
         end

         unique case (state)
            INIT_DRAW: begin
               if (last_px) begin
                  if (idx_last) begin
                     idx   <= '0;
                     state <= IDLE;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            IDLE: begin
               if (step && !dead)
                  state <= CALC;
            end
            CALC: begin
               cur_dir <= pend_dir;
               if (off) begin
                  dead  <= 1'b1;
                  state <= IDLE;
               end else begin
                  nh_x  <= nx[7:0];
                  nh_y  <= ny[6:0];
                  g     <= grow_pend && (length < LW'(MAX_LEN));
                  idx   <= '0;
                  state <= CHECK;
               end
            end
            CHECK: begin
               // The tail cell is free unless the snake grows this step.
               if (hit && !(idx_last && !g)) begin
                  dead  <= 1'b1;
                  state <= IDLE;
               end else if (idx_last) begin
                  xc    <= '0;
                  yc    <= '0;
                  state <= g ? SHIFT : ERASE;
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            ERASE: begin
               if (last_px)
                  state <= SHIFT;
            end
            SHIFT: begin
               for (int i = 1; i < MAX_LEN; i++) begin
                  seg_x[i] <= seg_x[i-1];
                  seg_y[i] <= seg_y[i-1];
               end
               seg_x[0] <= nh_x;
               seg_y[0] <= nh_y;
               if (g)
                  length <= length + LW'(1);
               state <= DRAW;
            end
            DRAW: begin
               if (last_px)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
